anycore_l15_req_scheduler: RTL and testbench

ANYCORE_L15_REQ_SCHEDULER -- requirements
Module: anycore_l15_req_scheduler

---
 rtl/anycore_l15_req_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_anycore_l15_req_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anycore_l15_req_scheduler.sv
// Purpose: captures icache-miss, dcache-load and dcache-store requests into one slot each
//          and issues them one at a time to the L1.5, with round-robin between the I and D classes.
// Latency/backpressure: l15_val rises two cycles after an x_val pulse. Requests hold in ISSUE until l15_ack.
//          A slot stays busy until the return arrives or the return timeout expires.
//          An x_val that arrives while its slot is busy is dropped and flags err_ovf.
// Ports: clk/rst_n (synchronous, active-low); ic/ld/st_val + addr (st also data/size) requester inputs;
//        l15_ack/l15_rtn_val handshake in; l15_val/rqtype/address/data/size/nc request out;
//        x_busy/x_done per requester; gnt_id owner (0 none, 1 ic, 2 ld, 3 st); sticky err_ovf/err_tmo.
module anycore_l15_req_scheduler #(
    parameter int PA_W        = 40,
    parameter int RTN_TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ic_val,
    input  logic [PA_W-1:0] ic_addr,
    input  logic            ld_val,
    input  logic [PA_W-1:0] ld_addr,
    input  logic            st_val,
    input  logic [PA_W-1:0] st_addr,
    input  logic [63:0]     st_data,
    input  logic [2:0]      st_size,
    input  logic            l15_ack,
    input  logic            l15_rtn_val,
    output logic            l15_val,
    output logic [4:0]      l15_rqtype,
    output logic [PA_W-1:0] l15_address,
    output logic [63:0]     l15_data,
    output logic [2:0]      l15_size,
    output logic            l15_nc,
    output logic            ic_busy,
    output logic            ld_busy,
    output logic            st_busy,
    output logic            ic_done,
    output logic            ld_done,
    output logic            st_done,
    output logic [1:0]      gnt_id,
    output logic            err_ovf,
    output logic            err_tmo
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RTN} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_IC   = 2'd1;
    localparam logic [1:0] G_LD   = 2'd2;
    localparam logic [1:0] G_ST   = 2'd3;

    localparam int TW = (RTN_TIMEOUT < 2) ? 1 : $clog2(RTN_TIMEOUT + 1);
    localparam int TMO_LAST_I = (RTN_TIMEOUT == 0) ? 0 : RTN_TIMEOUT - 1;
    localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];

    state_t          state_q, state_d;
    logic [PA_W-1:0] ic_addr_q, ld_addr_q, st_addr_q;
    logic [63:0]     st_data_q;
    logic [2:0]      st_size_q;
    logic            last_cls_i;   // 1: class I got the most recent grant
    logic            st_older;     // 1: store slot was captured before the load slot
    logic [TW-1:0]   tmo_cnt;

    logic            sel_vld;
    logic [1:0]      sel_id;
    logic            take_ack, take_rtn, take_tmo;

    assign l15_val = (state_q == S_ISSUE);
    assign l15_nc  = l15_address[PA_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        sel_vld  = 1'b0;
        sel_id   = G_NONE;
        take_ack = 1'b0;
        take_rtn = 1'b0;
        take_tmo = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ic_busy || ld_busy || st_busy) begin
                    sel_vld = 1'b1;
                    state_d = S_ISSUE;
                    // Class I wins when it is alone or when D was granted last.
                    if (ic_busy && (!(ld_busy || st_busy) || !last_cls_i))
                        sel_id = G_IC;
                    else if (ld_busy && (!st_busy || !st_older))
                        sel_id = G_LD;
                    else
                        sel_id = G_ST;
                end
            end
            S_ISSUE: begin
                // A return seen together with the ack belongs to nothing yet and is dropped.
                if (l15_ack) begin
                    take_ack = 1'b1;
                    state_d  = S_WAIT_RTN;
                end
            end
            S_WAIT_RTN: begin
                if (l15_rtn_val) begin
                    take_rtn = 1'b1;
                    state_d  = S_IDLE;
                end else if (RTN_TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                    take_tmo = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ic_busy     <= 1'b0;
            ld_busy     <= 1'b0;
            st_busy     <= 1'b0;
            ic_done     <= 1'b0;
            ld_done     <= 1'b0;
            st_done     <= 1'b0;
            ic_addr_q   <= '0;
            ld_addr_q   <= '0;
            st_addr_q   <= '0;
            st_data_q   <= '0;
            st_size_q   <= '0;
            err_ovf     <= 1'b0;
            err_tmo     <= 1'b0;
            last_cls_i  <= 1'b0;
            st_older    <= 1'b0;
            tmo_cnt     <= '0;
            gnt_id      <= G_NONE;
            l15_rqtype  <= '0;
            l15_address <= '0;
            l15_data    <= '0;
            l15_size    <= '0;
        end else begin
            ic_done <= 1'b0;
            ld_done <= 1'b0;
            st_done <= 1'b0;

            // Slots free on the return edge, so a pulse in the done cycle sees an empty slot.
            if (ic_val) begin
                if (ic_busy) err_ovf <= 1'b1;
                else begin
                    ic_busy   <= 1'b1;
                    ic_addr_q <= ic_addr;
                end
            end
            if (ld_val) begin
                if (ld_busy) err_ovf <= 1'b1;
                else begin
                    ld_busy   <= 1'b1;
                    ld_addr_q <= ld_addr;
                end
            end
            if (st_val) begin
                if (st_busy) err_ovf <= 1'b1;
                else begin
                    st_busy   <= 1'b1;
                    st_addr_q <= st_addr;
                    st_data_q <= st_data;
                    st_size_q <= st_size;
                end
            end

            // A fresh load is always younger than whatever store is held; a simultaneous
            // load/store capture therefore leaves the store as the older one.
            if (ld_val && !ld_busy)      st_older <= 1'b1;
            else if (st_val && !st_busy) st_older <= 1'b0;

            if (state_q == S_WAIT_RTN) tmo_cnt <= tmo_cnt + 1'b1;
            if (take_ack)              tmo_cnt <= '0;

            if (sel_vld) begin
                gnt_id     <= sel_id;
                last_cls_i <= (sel_id == G_IC);
                case (sel_id)
                    G_IC: begin
                        l15_rqtype  <= 5'b10000;
                        l15_address <= ic_addr_q;
                        l15_data    <= '0;
                        l15_size    <= 3'b010;
                    end
                    G_LD: begin
                        l15_rqtype  <= 5'b00000;
                        l15_address <= ld_addr_q;
                        l15_data    <= '0;
                        l15_size    <= 3'b010;
                    end
                    default: begin
                        l15_rqtype  <= 5'b00001;
                        l15_address <= st_addr_q;
                        l15_data    <= st_data_q;
                        l15_size    <= st_size_q;
                    end
                endcase
            end

            if (take_rtn || take_tmo) begin
                case (gnt_id)
                    G_IC: begin ic_busy <= 1'b0; ic_done <= take_rtn; end
                    G_LD: begin ld_busy <= 1'b0; ld_done <= take_rtn; end
                    G_ST: begin st_busy <= 1'b0; st_done <= take_rtn; end
                    default: ;
                endcase
                gnt_id      <= G_NONE;
                l15_rqtype  <= '0;
                l15_address <= '0;
                l15_data    <= '0;
                l15_size    <= '0;
                if (take_tmo) err_tmo <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_anycore_l15_req_scheduler.sv
// Purpose: directed self-checking bench for anycore_l15_req_scheduler.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Backpressure: l15_ack/l15_rtn_val are driven by the scenario tasks.
module tb_anycore_l15_req_scheduler;

    // 32-bit addresses make 0x00_8000_0040 carry its top bit, giving nc=1 for that vector.
    localparam int PA_W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ic_val, ld_val, st_val;
    logic [PA_W-1:0] ic_addr, ld_addr, st_addr;
    logic [63:0]     st_data;
    logic [2:0]      st_size;
    logic            l15_ack, l15_rtn_val;
    logic            l15_val, l15_nc;
    logic [4:0]      l15_rqtype;
    logic [PA_W-1:0] l15_address;
    logic [63:0]     l15_data;
    logic [2:0]      l15_size;
    logic            ic_busy, ld_busy, st_busy, ic_done, ld_done, st_done;
    logic [1:0]      gnt_id;
    logic            err_ovf, err_tmo;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    anycore_l15_req_scheduler #(.PA_W(PA_W), .RTN_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_val(ic_val), .ic_addr(ic_addr),
        .ld_val(ld_val), .ld_addr(ld_addr),
        .st_val(st_val), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .l15_ack(l15_ack), .l15_rtn_val(l15_rtn_val),
        .l15_val(l15_val), .l15_rqtype(l15_rqtype), .l15_address(l15_address),
        .l15_data(l15_data), .l15_size(l15_size), .l15_nc(l15_nc),
        .ic_busy(ic_busy), .ld_busy(ld_busy), .st_busy(st_busy),
        .ic_done(ic_done), .ld_done(ld_done), .st_done(st_done),
        .gnt_id(gnt_id), .err_ovf(err_ovf), .err_tmo(err_tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ack the issued request, wait one cycle in WAIT_RTN, then return it.
    // Ends just after the return edge (FSM in IDLE, done pulse visible).
    task automatic serve();
        l15_ack = 1'b1;
        step();
        l15_ack = 1'b0;
        step();
        l15_rtn_val = 1'b1;
        step();
        l15_rtn_val = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++;
        if ({l15_val, gnt_id, ic_busy, ld_busy, st_busy, err_ovf, err_tmo} !== 8'b0)
            $display("FAIL reset_ctl: got %b expected 0", {l15_val, gnt_id, ic_busy, ld_busy, st_busy, err_ovf, err_tmo});
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({l15_rqtype, l15_address, l15_data, l15_size, l15_nc} !== '0)
            $display("FAIL reset_dat: got %h expected 0", {l15_rqtype, l15_address, l15_data, l15_size, l15_nc});
        else n_pass++;
    endtask

    task automatic test_arb();
        ic_addr = 32'h0000_1000; ld_addr = 32'h0000_2000; st_addr = 32'h0000_3000;
        st_data = 64'hDEADBEEF_01234567; st_size = 3'b011;
        ic_val = 1'b1; ld_val = 1'b1; st_val = 1'b1;
        step();
        ic_val = 1'b0; ld_val = 1'b0; st_val = 1'b0;
        step();
        n_checks++;
        if ({l15_val, gnt_id, l15_rqtype, l15_size, l15_address, l15_data} !== {1'b1, 2'd1, 5'b10000, 3'b010, 32'h0000_1000, 64'd0})
            $display("FAIL arb_1st_ic: got %h expected %h", {l15_val, gnt_id, l15_rqtype, l15_size, l15_address, l15_data},
                     {1'b1, 2'd1, 5'b10000, 3'b010, 32'h0000_1000, 64'd0});
        else n_pass++;
        serve();
        step();
        n_checks++;
        if ({l15_val, gnt_id, l15_rqtype, l15_size, l15_address, l15_data} !== {1'b1, 2'd3, 5'b00001, 3'b011, 32'h0000_3000, 64'hDEADBEEF_01234567})
            $display("FAIL arb_2nd_st: got %h expected %h", {l15_val, gnt_id, l15_rqtype, l15_size, l15_address, l15_data},
                     {1'b1, 2'd3, 5'b00001, 3'b011, 32'h0000_3000, 64'hDEADBEEF_01234567});
        else n_pass++;
        serve();
        step();
        n_checks++;
        if ({l15_val, gnt_id, l15_rqtype, l15_size, l15_address, l15_data} !== {1'b1, 2'd2, 5'b00000, 3'b010, 32'h0000_2000, 64'd0})
            $display("FAIL arb_3rd_ld: got %h expected %h", {l15_val, gnt_id, l15_rqtype, l15_size, l15_address, l15_data},
                     {1'b1, 2'd2, 5'b00000, 3'b010, 32'h0000_2000, 64'd0});
        else n_pass++;
        serve();
        step();
    endtask

    task automatic test_single_ic();
        ic_addr = 32'h8000_0040;
        ic_val = 1'b1;
        step();
        ic_val = 1'b0;
        n_checks++;
        if ({ic_busy, l15_val} !== 2'b10)
            $display("FAIL ic_capture: got busy,val=%b expected 10", {ic_busy, l15_val});
        else n_pass++;
        step();
        n_checks++;
        if ({l15_val, l15_rqtype, l15_size, l15_nc, gnt_id, l15_address} !== {1'b1, 5'b10000, 3'b010, 1'b1, 2'd1, 32'h8000_0040})
            $display("FAIL ic_issue: got %h expected %h", {l15_val, l15_rqtype, l15_size, l15_nc, gnt_id, l15_address},
                     {1'b1, 5'b10000, 3'b010, 1'b1, 2'd1, 32'h8000_0040});
        else n_pass++;
        l15_ack = 1'b1;
        step();
        l15_ack = 1'b0;
        n_checks++;
        if ({l15_val, ic_busy} !== 2'b01)
            $display("FAIL ic_ack: got val,busy=%b expected 01", {l15_val, ic_busy});
        else n_pass++;
        step();
        l15_rtn_val = 1'b1;
        step();
        l15_rtn_val = 1'b0;
        n_checks++;
        if ({ic_done, ic_busy, gnt_id, l15_address} !== {1'b1, 1'b0, 2'd0, 32'd0})
            $display("FAIL ic_rtn: got %h expected %h", {ic_done, ic_busy, gnt_id, l15_address}, {1'b1, 1'b0, 2'd0, 32'd0});
        else n_pass++;
    endtask

    // Called in the done cycle left by test_single_ic: the freed slot captures at once.
    task automatic test_back_to_back();
        ic_addr = 32'h0000_0080;
        ic_val = 1'b1;
        step();
        ic_val = 1'b0;
        n_checks++;
        if ({ic_busy, ic_done, l15_val} !== 3'b100)
            $display("FAIL b2b_capture: got busy,done,val=%b expected 100", {ic_busy, ic_done, l15_val});
        else n_pass++;
        step();
        n_checks++;
        if ({l15_val, gnt_id, l15_address} !== {1'b1, 2'd1, 32'h0000_0080})
            $display("FAIL b2b_issue: got %h expected %h", {l15_val, gnt_id, l15_address}, {1'b1, 2'd1, 32'h0000_0080});
        else n_pass++;
        serve();
        step();
    endtask

    task automatic test_age();
        ic_addr = 32'h0000_0100; ld_addr = 32'h0000_0200; st_addr = 32'h0000_0300;
        st_data = 64'h55; st_size = 3'b001;
        ic_val = 1'b1;
        step();
        ic_val = 1'b0;
        step();
        ld_val = 1'b1;
        step();
        ld_val = 1'b0;
        st_val = 1'b1;
        step();
        st_val = 1'b0;
        serve();
        step();
        n_checks++;
        if ({gnt_id, l15_address} !== {2'd2, 32'h0000_0200})
            $display("FAIL age_ld_first: got %h expected %h", {gnt_id, l15_address}, {2'd2, 32'h0000_0200});
        else n_pass++;
        serve();
        step();
        n_checks++;
        if ({gnt_id, l15_address, l15_size} !== {2'd3, 32'h0000_0300, 3'b001})
            $display("FAIL age_st_next: got %h expected %h", {gnt_id, l15_address, l15_size}, {2'd3, 32'h0000_0300, 3'b001});
        else n_pass++;
        serve();
        step();
    endtask

    task automatic test_hold();
        ld_addr = 32'h1234_5680;
        ld_val = 1'b1;
        step();
        ld_val = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({l15_val, gnt_id, l15_rqtype, l15_size, l15_nc, l15_address, l15_data} !== {1'b1, 2'd2, 5'b00000, 3'b010, 1'b0, 32'h1234_5680, 64'd0})
                $display("FAIL hold_cyc%0d: got %h expected %h", i, {l15_val, gnt_id, l15_rqtype, l15_size, l15_nc, l15_address, l15_data},
                         {1'b1, 2'd2, 5'b00000, 3'b010, 1'b0, 32'h1234_5680, 64'd0});
            else n_pass++;
            l15_rtn_val = (i == 5);
            step();
        end
        l15_ack = 1'b1;
        l15_rtn_val = 1'b1;
        step();
        l15_ack = 1'b0;
        l15_rtn_val = 1'b0;
        n_checks++;
        if ({l15_val, ld_busy, ld_done, gnt_id} !== {1'b0, 1'b1, 1'b0, 2'd2})
            $display("FAIL hold_ack_rtn: got %b expected 01010", {l15_val, ld_busy, ld_done, gnt_id});
        else n_pass++;
        step();
        l15_rtn_val = 1'b1;
        step();
        l15_rtn_val = 1'b0;
        n_checks++;
        if ({ld_done, ld_busy} !== 2'b10)
            $display("FAIL hold_done: got done,busy=%b expected 10", {ld_done, ld_busy});
        else n_pass++;
        step();
    endtask

    task automatic test_ovf();
        st_addr = 32'h0000_0400; st_size = 3'b011;
        st_data = 64'h1;
        st_val = 1'b1;
        step();
        st_data = 64'h2;
        step();
        st_val = 1'b0;
        n_checks++;
        if ({err_ovf, l15_val, gnt_id, l15_data} !== {1'b1, 1'b1, 2'd3, 64'h1})
            $display("FAIL ovf: got %h expected %h", {err_ovf, l15_val, gnt_id, l15_data}, {1'b1, 1'b1, 2'd3, 64'h1});
        else n_pass++;
        serve();
        step();
    endtask

    task automatic test_timeout();
        ic_addr = 32'h0000_0500; ld_addr = 32'h0000_0600;
        ic_val = 1'b1; ld_val = 1'b1;
        step();
        ic_val = 1'b0; ld_val = 1'b0;
        step();
        n_checks++;
        if (gnt_id !== 2'd1)
            $display("FAIL tmo_grant: got %0d expected 1", gnt_id);
        else n_pass++;
        l15_ack = 1'b1;
        step();
        l15_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({err_tmo, ic_busy, ic_done, l15_val} !== 4'b0100)
                $display("FAIL tmo_wait%0d: got %b expected 0100", i, {err_tmo, ic_busy, ic_done, l15_val});
            else n_pass++;
            step();
        end
        step();
        n_checks++;
        if ({err_tmo, ic_busy, ic_done, gnt_id} !== 5'b10000)
            $display("FAIL tmo_fire: got %b expected 10000", {err_tmo, ic_busy, ic_done, gnt_id});
        else n_pass++;
        step();
        n_checks++;
        if ({l15_val, gnt_id, l15_address, ic_done} !== {1'b1, 2'd2, 32'h0000_0600, 1'b0})
            $display("FAIL tmo_next: got %h expected %h", {l15_val, gnt_id, l15_address, ic_done}, {1'b1, 2'd2, 32'h0000_0600, 1'b0});
        else n_pass++;
        serve();
        step();
    endtask

    task automatic test_reset_mid();
        st_addr = 32'h0000_0700; st_data = 64'h77; st_size = 3'b000;
        st_val = 1'b1;
        step();
        st_val = 1'b0;
        step();
        l15_ack = 1'b1;
        step();
        l15_ack = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        l15_rtn_val = 1'b1;
        step();
        l15_rtn_val = 1'b0;
        n_checks++;
        if ({st_done, ic_busy, ld_busy, st_busy, l15_val, gnt_id, err_ovf, err_tmo} !== 9'b0)
            $display("FAIL rstmid_state: got %b expected 0", {st_done, ic_busy, ld_busy, st_busy, l15_val, gnt_id, err_ovf, err_tmo});
        else n_pass++;
        step();
        n_checks++;
        if ({st_done, l15_val, l15_address} !== '0)
            $display("FAIL rstmid_after: got %h expected 0", {st_done, l15_val, l15_address});
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        ic_val = 1'b0; ld_val = 1'b0; st_val = 1'b0;
        ic_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; st_size = '0;
        l15_ack = 1'b0; l15_rtn_val = 1'b0;
        test_reset();
        test_arb();
        test_single_ic();
        test_back_to_back();
        test_age();
        test_hold();
        test_ovf();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
